aer_in_receiver: RTL and testbench
==================================

// Module: aer_in_receiver
// PURPOSE
// - AER receiver directly downstream of the rank-order encoder's aer_out link.
// - Completes the 4-phase REQ/ACK handshake and buffers pixel addresses in arrival (rank) order in a FIFO.
// - Presents the buffered addresses to the SNN input layer as a valid/ready event stream.
// - Counts events per image and flags image completion.
// PARAMETERS
// - IMAGE_SIZE       5                      pixels (= events) per image
// - IMAGE_SIZE_BITS  $clog2(IMAGE_SIZE)     address MSB index; address width is IMAGE_SIZE_BITS+1
// - FIFO_DEPTH       4                      event buffer entries; power of 2, >=2
// - FIFO_AW          $clog2(FIFO_DEPTH)     FIFO pointer width
// PORTS
// - CLK             in   1                  single clock, rising edge
// - RST             in   1                  reset; synchronous, active-low
// - AERIN_ADDR      in   IMAGE_SIZE_BITS+1  pixel address; bundled data, stable while AERIN_REQ=1
// - AERIN_REQ       in   1                  4-phase request from aer_out
// - AERIN_ACK       out  1                  4-phase acknowledge to aer_out
// - IMAGE_START     in   1                  1-cycle pulse: clears the event counter
// - EVENT_ADDR      out  IMAGE_SIZE_BITS+1  FIFO head address (show-ahead)
// - EVENT_VALID     out  1                  FIFO not empty
// - EVENT_READY     in   1                  consumer pop; a pop occurs when VALID&&READY
// - FIFO_FULL       out  1                  count == FIFO_DEPTH
// - IMAGE_RECEIVED  out  1                  1-cycle pulse when IMAGE_SIZE events have been accepted
// - EVENT_RANK      out  IMAGE_SIZE_BITS+1  only with AER_IN_RANK_EN: rank of head event, 0-based
// BEHAVIOUR
// - Reset (RST=0 at an edge):
//   - outputs: AERIN_ACK=0, EVENT_VALID=0, FIFO_FULL=0, IMAGE_RECEIVED=0, EVENT_ADDR=0, EVENT_RANK=0.
//   - internal: pointers, count and counter cleared; FSM=IDLE; sync flops=0.
// - Synchronizer: AERIN_REQ passes two flops to give req_s. AERIN_ADDR is sampled unsynchronized, only while req_s=1.
// - FSM IDLE (ACK=0):
//   - req_s=1 && !FIFO_FULL: push AERIN_ADDR, set ACK=1, go to WAIT_LOW.
//   - req_s=1 && FIFO_FULL: stay in IDLE; ACK stays 0. This is the backpressure path.
// - FSM WAIT_LOW (ACK=1):
//   - req_s=0: set ACK=0, go to IDLE.
//   - A new request is never accepted while in WAIT_LOW.
// - Latency:
//   - REQ first sampled high at edge n: push and ACK=1 at edge n+2. EVENT_VALID=1 from edge n+2 if the FIFO was empty.
//   - REQ sampled low at edge m: ACK=0 at edge m+2.
// - FIFO:
//   - Circular buffer; pointers wrap modulo FIFO_DEPTH; count width is FIFO_AW+1.
//   - Push and pop in the same cycle: count unchanged. This is legal when full because the push decision uses the registered FIFO_FULL; a pop frees the slot on the following cycle.
//   - Pop while empty: ignored.
// - Event counter:
//   - Increments on each push.
//   - On the push taking it to IMAGE_SIZE: IMAGE_RECEIVED=1 for one cycle and the counter returns to 0.
//   - IMAGE_START has priority over a same-cycle push: counter=0; the push is still stored and is not counted.
// - Reset mid-handshake: ACK drops at once. If REQ is still high after reset, the receiver accepts it as a new event.
// CONFIGURATION
// - Macro: AER_IN_RANK_EN.
// - Defined:
//   - Each FIFO entry also stores the event-counter value at push time.
//   - EVENT_RANK shows the rank of the head entry.
//   - Entry width is 2*(IMAGE_SIZE_BITS+1).
// - Undefined: EVENT_RANK port and rank storage are absent; entry width is IMAGE_SIZE_BITS+1.
// STRUCTURE
// - Package aer_pkg:
//   - typedef aer_addr_t (IMAGE_SIZE_BITS+1 bits).
//   - enum aer_in_state_t {IDLE, WAIT_LOW}.
//   - Entry struct holding addr and, under the macro, rank.
// - Sub-module aer_sync_fifo: parameterized FIFO with push, pop, dout, empty, full; same CLK/RST.
// - Top level contains the synchronizer, FSM and event counter.
// TESTING
// - Reset: hold RST=0 for 3 cycles with REQ=1 -> ACK=0, VALID=0, FULL=0; after release, ACK=1 two cycles later.
// - Single event: ADDR=3, REQ 0->1 at edge n -> ACK=1 at n+2, EVENT_ADDR=3, VALID=1. REQ low at m -> ACK=0 at m+2.
// - Full/backpressure: READY=0, send 4 events -> FULL=1. A 5th REQ gets no ACK. One pop -> ACK follows within 2 cycles and FIFO returns to 4 entries.
// - Ordering and completion: send addresses 4,0,2,1,3 with READY=1 -> pops in the same order; IMAGE_RECEIVED pulses once on the 5th push; EVENT_RANK=0..4 with the macro defined.
// - IMAGE_START collides with a push after 2 counted events -> counter=0 and the event is stored; 5 further events are needed before IMAGE_RECEIVED.
// - Simultaneous push and pop at count=1 -> count stays 1; head advances to the new address.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared types and sizing for the AER input receiver.
// Optional rank storage is enabled by the AER_IN_RANK_EN macro.
package aer_pkg;
  localparam int IMAGE_SIZE      = 5;
  localparam int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE);
  localparam int ADDR_W          = IMAGE_SIZE_BITS + 1;
  localparam int FIFO_DEPTH      = 4;
  localparam int FIFO_AW         = $clog2(FIFO_DEPTH);

  typedef logic [ADDR_W-1:0] aer_addr_t;

  typedef enum logic {IDLE, WAIT_LOW} aer_in_state_t;

  typedef struct packed {
`ifdef AER_IN_RANK_EN
    aer_addr_t rank;
`endif
    aer_addr_t addr;
  } aer_entry_t;

  localparam int ENTRY_W = $bits(aer_entry_t);
endpackage

// File: rtl/aer_in_receiver_if.sv
// AER link plus event stream bundle; the receiver is the slave side.
// EVENT_RANK exists only when AER_IN_RANK_EN is defined.
interface aer_in_receiver_if;
  import aer_pkg::*;

  aer_addr_t AERIN_ADDR;
  logic      AERIN_REQ;
  logic      AERIN_ACK;
  logic      IMAGE_START;
  aer_addr_t EVENT_ADDR;
  logic      EVENT_VALID;
  logic      EVENT_READY;
  logic      FIFO_FULL;
  logic      IMAGE_RECEIVED;
`ifdef AER_IN_RANK_EN
  aer_addr_t EVENT_RANK;
`endif

  modport slave (
    input  AERIN_ADDR, AERIN_REQ, IMAGE_START, EVENT_READY,
    output AERIN_ACK, EVENT_ADDR, EVENT_VALID, FIFO_FULL, IMAGE_RECEIVED
`ifdef AER_IN_RANK_EN
    , output EVENT_RANK
`endif
  );

  modport master (
    output AERIN_ADDR, AERIN_REQ, IMAGE_START, EVENT_READY,
    input  AERIN_ACK, EVENT_ADDR, EVENT_VALID, FIFO_FULL, IMAGE_RECEIVED
`ifdef AER_IN_RANK_EN
    , input EVENT_RANK
`endif
  );
endinterface

// File: rtl/aer_sync_fifo.sv
// Show-ahead circular FIFO; head reads as zero while empty so outputs are clean after reset.
module aer_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer only lands if the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/aer_in_receiver.sv
// 4-phase AER receiver: REQ synchronizer, handshake FSM, event FIFO and per-image counter.
// Define AER_IN_RANK_EN to store and expose the rank of each buffered event.
module aer_in_receiver
  import aer_pkg::*;
(
  input logic              CLK,
  input logic              RST,
  aer_in_receiver_if.slave bus
);
  logic [1:0]    sync_reg;
  logic          req_s;
  aer_in_state_t state_reg, state_next;
  logic          push;
  aer_addr_t     cnt_reg;
  logic          received_reg;
  logic          fifo_empty, fifo_full;
  aer_entry_t    entry_in, entry_out;

  assign req_s = sync_reg[1];

  always_ff @(posedge CLK) begin
    if (!RST) sync_reg <= '0;
    else      sync_reg <= {sync_reg[0], bus.AERIN_REQ};
  end

  always_ff @(posedge CLK) begin
    if (!RST) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Backpressure: a request seen while full simply waits in IDLE with ACK low.
  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_s && !fifo_full) begin
          push       = 1'b1;
          state_next = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!req_s) state_next = IDLE;
      end
    endcase
  end

  // IMAGE_START wins over a coincident push: the event is buffered but not counted.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_reg      <= '0;
      received_reg <= 1'b0;
    end else begin
      received_reg <= 1'b0;
      if (bus.IMAGE_START) begin
        cnt_reg <= '0;
      end else if (push) begin
        if (cnt_reg == ADDR_W'(IMAGE_SIZE - 1)) begin
          cnt_reg      <= '0;
          received_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  always_comb begin
    entry_in      = '0;
    entry_in.addr = bus.AERIN_ADDR;
`ifdef AER_IN_RANK_EN
    entry_in.rank = cnt_reg;
`endif
  end

  aer_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (bus.EVENT_READY),
    .din   (entry_in),
    .dout  (entry_out),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.AERIN_ACK      = (state_reg == WAIT_LOW);
  assign bus.EVENT_ADDR     = entry_out.addr;
  assign bus.EVENT_VALID    = !fifo_empty;
  assign bus.FIFO_FULL      = fifo_full;
  assign bus.IMAGE_RECEIVED = received_reg;
`ifdef AER_IN_RANK_EN
  assign bus.EVENT_RANK     = entry_out.rank;
`endif
endmodule

// File: tb/tb_aer_in_receiver.sv
// Directed self-checking bench for aer_in_receiver (handshake, backpressure, ordering, counter).
module tb_aer_in_receiver;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  bit   mon_en = 1'b0;
  int   addr_q[$];
  int   rank_q[$];

  always #5 clk = ~clk;

  aer_in_receiver_if bus ();

  aer_in_receiver dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Records pops and IMAGE_RECEIVED pulses away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.EVENT_VALID && bus.EVENT_READY) begin
        addr_q.push_back(int'(bus.EVENT_ADDR));
`ifdef AER_IN_RANK_EN
        rank_q.push_back(int'(bus.EVENT_RANK));
`endif
      end
      if (bus.IMAGE_RECEIVED) pulses++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input logic val, input string tag);
    for (int i = 0; i < 20 && bus.AERIN_ACK !== val; i++) @(negedge clk);
    check(tag, bus.AERIN_ACK, val);
  endtask

  task automatic send_event(input int addr);
    bus.AERIN_ADDR = 4'(addr);
    bus.AERIN_REQ  = 1'b1;
    wait_ack(1'b1, "send_ack_high");
    bus.AERIN_REQ  = 1'b0;
    wait_ack(1'b0, "send_ack_low");
    $display("event addr=%0d handshake done", addr);
  endtask

  task automatic pop_expect(input int exp, input string tag);
    check({tag, "_valid"}, bus.EVENT_VALID, 1'b1);
    check(tag, bus.EVENT_ADDR, exp);
    bus.EVENT_READY = 1'b1;
    @(negedge clk);
    bus.EVENT_READY = 1'b0;
    $display("pop addr=%0d", exp);
  endtask

  task automatic pulse_start();
    bus.IMAGE_START = 1'b1;
    @(negedge clk);
    bus.IMAGE_START = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5];
    logic [31:0] got;
    exp_order = '{4, 0, 2, 1, 3};

    // Reset held with REQ high; request is accepted once reset releases.
    rst = 1'b0;
    bus.AERIN_ADDR = 4'd2;
    bus.AERIN_REQ = 1'b1;
    bus.IMAGE_START = 1'b0;
    bus.EVENT_READY = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", bus.AERIN_ACK, 1'b0);
    check("rst_valid", bus.EVENT_VALID, 1'b0);
    check("rst_full", bus.FIFO_FULL, 1'b0);
    check("rst_addr", bus.EVENT_ADDR, 0);
    check("rst_recv", bus.IMAGE_RECEIVED, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ack_e2", bus.AERIN_ACK, 1'b0);
    @(negedge clk);
    check("rst_ack_e3", bus.AERIN_ACK, 1'b1);
    check("rst_evt_valid", bus.EVENT_VALID, 1'b1);
    check("rst_evt_addr", bus.EVENT_ADDR, 2);
    bus.AERIN_REQ = 1'b0;
    wait_ack(1'b0, "rst_ack_low");
    pop_expect(2, "rst_pop");
    check("rst_empty", bus.EVENT_VALID, 1'b0);
    pulse_start();

    // Single event latency.
    bus.AERIN_ADDR = 4'd3;
    bus.AERIN_REQ = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("single_ack_n1", bus.AERIN_ACK, 1'b0);
    @(negedge clk);
    check("single_ack_n2", bus.AERIN_ACK, 1'b1);
    check("single_addr", bus.EVENT_ADDR, 3);
    check("single_valid", bus.EVENT_VALID, 1'b1);
    bus.AERIN_REQ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("single_ack_m1", bus.AERIN_ACK, 1'b1);
    @(negedge clk);
    check("single_ack_m2", bus.AERIN_ACK, 1'b0);
    pop_expect(3, "single_pop");
    pulse_start();

    // Full and backpressure.
    for (int i = 1; i <= 4; i++) send_event(i);
    check("bp_full", bus.FIFO_FULL, 1'b1);
    check("bp_head", bus.EVENT_ADDR, 1);
    bus.AERIN_ADDR = 4'd5;
    bus.AERIN_REQ = 1'b1;
    repeat (6) @(negedge clk);
    check("bp_no_ack", bus.AERIN_ACK, 1'b0);
    bus.EVENT_READY = 1'b1;
    @(negedge clk);
    bus.EVENT_READY = 1'b0;
    check("bp_full_after_pop", bus.FIFO_FULL, 1'b0);
    @(negedge clk);
    check("bp_ack_after_pop", bus.AERIN_ACK, 1'b1);
    check("bp_full_again", bus.FIFO_FULL, 1'b1);
    check("bp_head_after_pop", bus.EVENT_ADDR, 2);
    check("bp_recv_pulse", bus.IMAGE_RECEIVED, 1'b1);
    bus.AERIN_REQ = 1'b0;
    wait_ack(1'b0, "bp_ack_low");
    for (int i = 2; i <= 5; i++) pop_expect(i, "bp_drain");
    check("bp_drained", bus.EVENT_VALID, 1'b0);

    // Ordering and image completion with a free-running consumer.
    addr_q.delete();
    rank_q.delete();
    pulses = 0;
    bus.EVENT_READY = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) send_event(exp_order[i]);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    bus.EVENT_READY = 1'b0;
    check("order_count", addr_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      got = (i < addr_q.size()) ? addr_q[i] : 32'hFFFF;
      check("order_addr", got, exp_order[i]);
`ifdef AER_IN_RANK_EN
      got = (i < rank_q.size()) ? rank_q[i] : 32'hFFFF;
      check("order_rank", got, i);
`endif
    end
    check("order_pulses", pulses, 1);

    // IMAGE_START colliding with the third push.
    pulses = 0;
    bus.EVENT_READY = 1'b1;
    mon_en = 1'b1;
    send_event(6);
    send_event(7);
    bus.EVENT_READY = 1'b0;
    bus.AERIN_ADDR = 4'd8;
    bus.AERIN_REQ = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.IMAGE_START = 1'b1;
    @(negedge clk);
    bus.IMAGE_START = 1'b0;
    check("coll_ack", bus.AERIN_ACK, 1'b1);
    check("coll_valid", bus.EVENT_VALID, 1'b1);
    check("coll_addr", bus.EVENT_ADDR, 8);
    bus.AERIN_REQ = 1'b0;
    wait_ack(1'b0, "coll_ack_low");
    bus.EVENT_READY = 1'b1;
    for (int i = 9; i <= 12; i++) send_event(i);
    repeat (2) @(negedge clk);
    check("coll_pulses_4", pulses, 0);
    send_event(13);
    repeat (2) @(negedge clk);
    check("coll_pulses_5", pulses, 1);
    mon_en = 1'b0;
    bus.EVENT_READY = 1'b0;
    @(negedge clk);
    check("coll_empty", bus.EVENT_VALID, 1'b0);

    // Simultaneous push and pop at one entry.
    send_event(9);
    bus.AERIN_ADDR = 4'd10;
    bus.AERIN_REQ = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.EVENT_READY = 1'b1;
    @(negedge clk);
    bus.EVENT_READY = 1'b0;
    check("pp_ack", bus.AERIN_ACK, 1'b1);
    check("pp_valid", bus.EVENT_VALID, 1'b1);
    check("pp_head", bus.EVENT_ADDR, 10);
    check("pp_not_full", bus.FIFO_FULL, 1'b0);
    bus.AERIN_REQ = 1'b0;
    wait_ack(1'b0, "pp_ack_low");
    pop_expect(10, "pp_pop");
    check("pp_empty", bus.EVENT_VALID, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
